// File: rtl/mem_stage_if.sv
// Bundles the pipeline request, RAM port and write-back signals of the memory stage.
interface mem_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RAM_AW = 17,
    parameter int unsigned REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        req_kind;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [REG_AW-1:0] req_rd;
    logic [XLEN-1:0]   req_data;
    logic [XLEN-1:0]   req_sdata;
    logic              ram_grant;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              stall_req;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;

    // Upstream pipeline / memory controller side
    modport master (
        output in_valid, req_kind, req_size, req_unsigned, req_rd, req_data, req_sdata,
        output ram_grant, ram_din,
        input  in_ready, ram_en, ram_we, ram_addr, ram_dout, stall_req,
        input  wb_en, wb_addr, wb_data
    );

    // Memory stage side
    modport slave (
        input  in_valid, req_kind, req_size, req_unsigned, req_rd, req_data, req_sdata,
        input  ram_grant, ram_din,
        output in_ready, ram_en, ram_we, ram_addr, ram_dout, stall_req,
        output wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/mem_stage_seq.sv
// Registered memory-access stage: serialises loads/stores into byte-wide RAM
// cycles, extends load data and produces one registered write-back per request.
module mem_stage_seq #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RAM_AW = 17,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned RD_LAT = 1
) (
    input logic       clk,
    input logic       rst,
    mem_stage_if.slave bus
);
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 3;

    localparam logic [1:0] K_PASS  = 2'b00;
    localparam logic [1:0] K_LOAD  = 2'b01;
    localparam logic [1:0] K_STORE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ST_BYTE,
        RD_ISSUE,
        RD_WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   asm_q, asm_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [RAM_AW-1:0] base_q, base_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic accept_c;
    logic legal_c;

    // Index of the final byte for a given access size
    function automatic logic [IW-1:0] last_idx(input logic [1:0] sz);
        case (sz)
            2'd0:    last_idx = IW'(0);
            2'd1:    last_idx = IW'(1);
            2'd2:    last_idx = IW'(3);
            default: last_idx = IW'(7);
        endcase
    endfunction

    // Sign or zero extension of the assembled load bytes
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input logic [1:0] sz,
                                               input logic uns);
        logic [XLEN-1:0] r;
        r = v;
        case (sz)
            2'd0:    r = uns ? XLEN'(v[7:0])  : XLEN'($signed(v[7:0]));
            2'd1:    r = uns ? XLEN'(v[15:0]) : XLEN'($signed(v[15:0]));
            2'd2:    r = uns ? XLEN'(v[31:0]) : XLEN'($signed(v[31:0]));
            default: r = v;
        endcase
        return r;
    endfunction

    assign accept_c = bus.in_valid && in_ready_q;
    // Double-word accesses only exist on a 64-bit datapath
    assign legal_c  = (bus.req_size != 2'd3) || (XLEN == 64);

    assign bus.in_ready  = in_ready_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    // Stall covers the accepting cycle of a memory op plus all busy states
    assign bus.stall_req = busy_q ||
                           (accept_c && (bus.req_kind == K_LOAD || bus.req_kind == K_STORE));

    // Next-state, request latching and registered-output computation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        size_d    = size_q;
        uns_d     = uns_q;
        rd_d      = rd_q;
        base_d    = base_q;
        sdata_d   = sdata_q;
        wb_en_d   = 1'b0;
        wb_addr_d = '0;
        wb_data_d = '0;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    rd_d    = bus.req_rd;
                    base_d  = bus.req_data[RAM_AW-1:0];
                    sdata_d = bus.req_sdata;
                    idx_d   = '0;
                    asm_d   = '0;
                    case (bus.req_kind)
                        K_PASS: begin
                            if (bus.req_rd != '0) begin
                                wb_en_d   = 1'b1;
                                wb_addr_d = bus.req_rd;
                                wb_data_d = bus.req_data;
                            end
                        end
                        K_LOAD:  if (legal_c) state_d = RD_ISSUE;
                        K_STORE: if (legal_c) state_d = ST_BYTE;
                        default: ;
                    endcase
                end
            end
            ST_BYTE: begin
                if (bus.ram_grant) begin
                    if (idx_q == last_idx(size_q)) state_d = DONE;
                    else                           idx_d   = idx_q + IW'(1);
                end
            end
            RD_ISSUE: begin
                if (bus.ram_grant) begin
                    state_d = RD_WAIT;
                    cnt_d   = CW'(RD_LAT);
                end
            end
            RD_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    asm_d = asm_q | (XLEN'(bus.ram_din) << {idx_q, 3'b000});
                    if (idx_q == last_idx(size_q)) begin
                        state_d = DONE;
                        if (rd_q != '0) begin
                            wb_en_d   = 1'b1;
                            wb_addr_d = rd_q;
                            wb_data_d = extend(asm_d, size_q, uns_q);
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = RD_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE) && (state_d != DONE);
        ram_en_d   = (state_d == ST_BYTE) || (state_d == RD_ISSUE);
        ram_we_d   = (state_d == ST_BYTE);
        ram_addr_d = ram_en_d ? (base_d + RAM_AW'(idx_d)) : '0;
        ram_dout_d = ram_we_d ? 8'(sdata_d >> {idx_d, 3'b000}) : 8'h00;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            asm_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            base_q     <= '0;
            sdata_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            base_q     <= base_d;
            sdata_q    <= sdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end
endmodule

// File: tb/tb_mem_stage_seq.sv
// Bench for mem_stage_seq: byte-addressed RAM with fixed read latency, a
// request-level reference model, directed cases and randomised traffic.
module tb_mem_stage_seq;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RAM_AW = 17;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned MEM_SZ = 1 << RAM_AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if #(.XLEN(XLEN), .RAM_AW(RAM_AW), .REG_AW(REG_AW)) bus ();

    mem_stage_seq #(.XLEN(XLEN), .RAM_AW(RAM_AW), .REG_AW(REG_AW), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0]        mem     [MEM_SZ];
    logic [7:0]        ref_mem [MEM_SZ];
    logic              pv      [RD_LAT];
    logic [RAM_AW-1:0] pa      [RD_LAT];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // RAM: writes on a granted write cycle, read data RD_LAT cycles after a granted read
    always @(posedge clk) begin
        if (!rst && bus.ram_en && bus.ram_grant && bus.ram_we) mem[bus.ram_addr] = bus.ram_dout;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pv[k] <= 1'b0;
                pa[k] <= '0;
            end
        end else begin
            pv[0] <= bus.ram_en && bus.ram_grant && !bus.ram_we;
            pa[0] <= bus.ram_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
            end
        end
    end

    assign bus.ram_din = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : 8'hC3;

    // Expected load value from the reference memory image
    function automatic logic [63:0] exp_load(input logic [RAM_AW-1:0] addr, input logic [1:0] size,
                                             input logic uns);
        int n;
        logic [63:0] v;
        n = 1 << size;
        v = '0;
        for (int k = 0; k < n; k++) v = v | (64'(ref_mem[RAM_AW'(addr + k)]) << (8 * k));
        if (!uns && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return 64'(XLEN'(v));
    endfunction

    task automatic run_req(input logic [1:0] kind, input logic [1:0] size, input logic uns,
                           input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data,
                           input logic [XLEN-1:0] sdata, input int gmode,
                           output logic [XLEN-1:0] wbd);
        logic legal, is_ld, is_st, gr, p_en, p_gr, seen_idle;
        logic [RAM_AW-1:0] base, p_addr;
        logic [XLEN-1:0] exp_wb;
        int n, ungr, wb_cnt, wb_cyc, done_cnt, g, cyc;
        legal = (size != 2'd3);
        is_ld = legal && (kind == 2'd1);
        is_st = legal && (kind == 2'd2);
        n = 1 << size;
        base = data[RAM_AW-1:0];
        exp_wb = (kind == 2'd0) ? data : (is_ld ? XLEN'(exp_load(base, size, uns)) : '0);
        ungr = 0; wb_cnt = 0; wb_cyc = -1; done_cnt = 0; g = 0;
        wbd = '0; p_en = 1'b0; p_gr = 1'b0; p_addr = '0; seen_idle = 1'b0;

        @(negedge clk);
        bus.in_valid     = 1'b1;
        bus.req_kind     = kind;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_rd       = rd;
        bus.req_data     = data;
        bus.req_sdata    = sdata;
        bus.ram_grant    = 1'b0;
        #1;
        chk("acc_ready", 64'(bus.in_ready), 64'd1);
        chk("acc_stall", 64'(bus.stall_req), 64'((kind == 2'd1) || (kind == 2'd2)));
        @(posedge clk);
        if (is_st) for (int k = 0; k < n; k++) ref_mem[RAM_AW'(base + k)] = 8'(sdata >> (8 * k));
        @(negedge clk);
        bus.in_valid     = 1'b0;
        bus.req_kind     = 2'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_rd       = REG_AW'($urandom);
        bus.req_data     = XLEN'($urandom);
        bus.req_sdata    = XLEN'($urandom);
        cyc = 1;
        while (cyc <= 300 && !seen_idle) begin
            if (bus.wb_en) begin
                wb_cnt++;
                wb_cyc = cyc;
                wbd = bus.wb_data;
                chk("wb_addr", 64'(bus.wb_addr), 64'(rd));
                chk("wb_data", 64'(bus.wb_data), 64'(exp_wb));
            end else begin
                chk("wb_idle", 64'({bus.wb_addr, bus.wb_data}), 64'd0);
            end
            if (bus.ram_en) begin
                chk("ram_addr", 64'(bus.ram_addr), 64'(RAM_AW'(base + g)));
                chk("ram_we", 64'(bus.ram_we), 64'(is_st));
                if (is_st) chk("ram_dout", 64'(bus.ram_dout), 64'(8'(sdata >> (8 * g))));
            end
            if (p_en && !p_gr && bus.ram_en) chk("addr_hold", 64'(bus.ram_addr), 64'(p_addr));
            if (!bus.in_ready && !bus.stall_req) done_cnt++;
            if (bus.in_ready) begin
                seen_idle = 1'b1;
            end else begin
                case (gmode)
                    0:       gr = 1'b1;
                    1:       gr = ($urandom_range(0, 2) != 0);
                    default: gr = (cyc % 2 == 0);
                endcase
                bus.ram_grant = gr;
                if (bus.ram_en && !gr) ungr++;
                if (bus.ram_en && gr) g++;
                p_en = bus.ram_en;
                p_gr = gr;
                p_addr = bus.ram_addr;
                @(negedge clk);
                cyc++;
            end
        end
        chk("timeout", 64'(seen_idle), 64'd1);
        if (is_st) begin
            chk("st_len", 64'(cyc), 64'(n + 2 + ungr));
            chk("st_wb", 64'(wb_cnt), 64'd0);
            chk("st_done", 64'(done_cnt), 64'd1);
            for (int k = 0; k < n; k++)
                chk("st_mem", 64'(mem[RAM_AW'(base + k)]), 64'(ref_mem[RAM_AW'(base + k)]));
        end else if (is_ld) begin
            chk("ld_len", 64'(cyc), 64'(n * (RD_LAT + 1) + 2 + ungr));
            chk("ld_wb", 64'(wb_cnt), 64'(rd != '0));
            if (rd != '0) chk("ld_lat", 64'(wb_cyc), 64'(n * (RD_LAT + 1) + 1 + ungr));
            chk("ld_done", 64'(done_cnt), 64'd1);
        end else begin
            chk("nop_len", 64'(cyc), 64'd1);
            chk("nop_wb", 64'(wb_cnt), 64'((kind == 2'd0) && (rd != '0)));
        end
    endtask

    // Back-to-back pass requests, one accepted every cycle
    task automatic pass_burst(input int cnt);
        logic [REG_AW-1:0] prd;
        logic [XLEN-1:0] pdat;
        prd = '0;
        pdat = '0;
        for (int i = 0; i <= cnt; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("burst_en", 64'(bus.wb_en), 64'(prd != '0));
                chk("burst_addr", 64'(bus.wb_addr), 64'(prd));
                chk("burst_data", 64'(bus.wb_data), (prd != '0) ? 64'(pdat) : 64'd0);
            end
            chk("burst_ready", 64'(bus.in_ready), 64'd1);
            if (i < cnt) begin
                prd  = REG_AW'($urandom);
                pdat = XLEN'($urandom);
                bus.in_valid = 1'b1;
                bus.req_kind = 2'd0;
                bus.req_rd   = prd;
                bus.req_data = pdat;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    endtask

    logic [XLEN-1:0] r;
    logic [RAM_AW-1:0] pool [4];

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.req_kind = 2'd3; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_rd = '0; bus.req_data = '0; bus.req_sdata = '0; bus.ram_grant = 1'b0;
        for (int i = 0; i < int'(MEM_SZ); i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_ram_en", 64'(bus.ram_en), 64'd0);
        chk("rst_stall", 64'(bus.stall_req), 64'd0);
        chk("rst_wb", 64'({bus.wb_en, bus.wb_addr, bus.wb_data}), 64'd0);
        rst = 1'b0;

        run_req(2'd0, 2'd2, 1'b0, 5'd5, 32'h0000_1234, '0, 0, r);
        chk("pass_val", 64'(r), 64'h1234);
        run_req(2'd0, 2'd2, 1'b0, 5'd0, 32'h0000_5678, '0, 0, r);
        run_req(2'd2, 2'd2, 1'b0, 5'd9, 32'h0000_0100, 32'hDEAD_BEEF, 0, r);
        chk("sw_b0", 64'(mem[17'h100]), 64'hEF);
        chk("sw_b3", 64'(mem[17'h103]), 64'hDE);
        run_req(2'd1, 2'd0, 1'b0, 5'd1, 32'h0000_0100, '0, 0, r);
        chk("lb", 64'(r), 64'hFFFF_FFEF);
        run_req(2'd1, 2'd0, 1'b1, 5'd2, 32'h0000_0100, '0, 0, r);
        chk("lbu", 64'(r), 64'h0000_00EF);
        run_req(2'd1, 2'd1, 1'b0, 5'd3, 32'h0000_0102, '0, 0, r);
        chk("lh", 64'(r), 64'hFFFF_DEAD);
        run_req(2'd1, 2'd2, 1'b0, 5'd4, 32'h0000_0100, '0, 2, r);
        chk("lw_toggle", 64'(r), 64'hDEAD_BEEF);
        run_req(2'd1, 2'd2, 1'b0, 5'd0, 32'h0000_0100, '0, 0, r);
        run_req(2'd2, 2'd1, 1'b0, 5'd0, 32'h0001_FFFF, 32'h0000_A55A, 0, r);
        chk("sh_wrap_hi", 64'(mem[17'h1FFFF]), 64'h5A);
        chk("sh_wrap_lo", 64'(mem[17'h00000]), 64'hA5);
        run_req(2'd1, 2'd3, 1'b0, 5'd7, 32'h0000_0100, '0, 0, r);

        // Reset in the middle of a word store, after its first byte
        @(negedge clk);
        bus.in_valid = 1'b1; bus.req_kind = 2'd2; bus.req_size = 2'd2; bus.req_rd = 5'd0;
        bus.req_data = 32'h0000_0200; bus.req_sdata = 32'h1122_3344;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.ram_grant = 1'b1;
        @(negedge clk);
        chk("rst_mid_pre", 64'({bus.ram_en, bus.ram_addr}), 64'({1'b1, 17'h201}));
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_en", 64'(bus.ram_en), 64'd0);
        chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_wb", 64'(bus.wb_en), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_mem[17'h200] = 8'h44;
        run_req(2'd1, 2'd2, 1'b0, 5'd6, 32'h0000_0200, '0, 0, r);

        pool[0] = 17'h00100; pool[1] = 17'h1FFFC; pool[2] = 17'h00008; pool[3] = 17'h00400;
        for (int t = 0; t < 80; t++) begin
            logic [RAM_AW-1:0] a;
            logic [REG_AW-1:0] rdr;
            a = pool[$urandom_range(0, 3)] + RAM_AW'($urandom_range(0, 7));
            rdr = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
            run_req(2'($urandom), 2'($urandom), 1'($urandom), rdr,
                    {15'($urandom), a}, XLEN'($urandom), int'($urandom_range(0, 2)), r);
        end

        pass_burst(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
